spi_master_tx: RTL and testbench

//  Byte-oriented SPI master transmitter. Upstream neighbour of the SPI receive slave: drives SPCK/MOSI/CS_n.

---
 rtl/spi_master_tx_pkg.sv | 36 +++
 rtl/spi_master_tx_clkgen.sv | 73 +++++++
 rtl/spi_master_tx.sv | 161 ++++++++++++++++
 tb/tb_spi_master_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_tx_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_tx_pkg
// Shared definitions for the SPI master transmitter:
//   - txState_t      : FSM state encoding (IDLE/SETUP/SHIFT/WAIT/HOLD/GAP)
//   - EDGES_PER_BYTE : SPCK edges that make up one byte on the wire
//   - modeCpol/Cpha  : decode clock polarity / phase from the SPI mode number
//   - maxInt         : helper for sizing shared delay counters
// -----------------------------------------------------------------------------
package spi_master_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_WAIT,
      ST_HOLD,
      ST_GAP
   } txState_t;

   localparam int EDGES_PER_BYTE = 16;

   // CPOL is bit 1 of the SPI mode number
   function automatic logic modeCpol(input int mode);
      return mode[1];
   endfunction

   // CPHA is bit 0 of the SPI mode number
   function automatic logic modeCpha(input int mode);
      return mode[0];
   endfunction

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_master_tx_clkgen.sv
// -----------------------------------------------------------------------------
// spi_master_tx_clkgen
// SPCK generator for the SPI master transmitter. While i_Run is high it counts
// CLKS_PER_HALF_BIT clk cycles per half period and toggles SPCK, counting the
// edges of the current byte. While i_Run is low everything parks: SPCK sits at
// CPOL and the counters are cleared, so the first edge always comes a full
// half period after i_Run rises.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   i_Run        : enable the half-bit counter
//   o_SPCK       : registered SPI clock
//   o_Leading    : strobe, the next clk edge produces a leading SPCK edge
//   o_Trailing   : strobe, the next clk edge produces a trailing SPCK edge
//   o_LastEdge   : strobe, the next clk edge produces edge 16 of the byte
//   o_ByteDone   : high for the one cycle in which edge 16 is visible on SPCK
// -----------------------------------------------------------------------------
module spi_master_tx_clkgen
   import spi_master_tx_pkg::*;
#(
   parameter int   CLKS_PER_HALF_BIT = 2,
   parameter logic CPOL              = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_Run,
   output logic o_SPCK,
   output logic o_Leading,
   output logic o_Trailing,
   output logic o_LastEdge,
   output logic o_ByteDone
);

   localparam int              HW        = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
   localparam logic [HW-1:0]   HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [3:0]      EDGE_LAST = 4'(EDGES_PER_BYTE - 1);

   logic [HW-1:0] r_halfCnt;
   logic [3:0]    r_edgeCnt;
   logic          r_spck;
   logic          r_byteDone;
   logic          w_tick;

   // An even edge count means the coming edge moves SPCK away from CPOL,
   // i.e. it is a leading edge; odd counts give trailing edges.
   assign w_tick     = i_Run && (r_halfCnt == HALF_LAST);
   assign o_Leading  = w_tick && !r_edgeCnt[0];
   assign o_Trailing = w_tick &&  r_edgeCnt[0];
   assign o_LastEdge = w_tick && (r_edgeCnt == EDGE_LAST);
   assign o_SPCK     = r_spck;
   assign o_ByteDone = r_byteDone;

   // Half-bit counter, SPCK toggle and edge counter. The edge counter wraps
   // from 15 to 0 on edge 16, so a following byte starts from a clean count
   // without i_Run ever dropping.
   always_ff @(posedge clk) begin
      if (rst || !i_Run) begin
         r_halfCnt  <= '0;
         r_edgeCnt  <= '0;
         r_spck     <= CPOL;
         r_byteDone <= 1'b0;
      end else begin
         r_byteDone <= o_LastEdge;
         if (w_tick) begin
            r_halfCnt <= '0;
            r_edgeCnt <= r_edgeCnt + 4'd1;
            r_spck    <= ~r_spck;
         end else begin
            r_halfCnt <= r_halfCnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
// Byte-oriented SPI master transmitter. Bytes arrive over a valid/ready
// handshake and are shifted out MSB-first in SPI mode SPI_MODE. Consecutive
// bytes share one CS_n assertion until a byte flagged "last" closes the frame,
// after which CS_n stays high for at least CS_INACTIVE_CLKS cycles.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   i_TX_Byte   : byte to send, captured on handshake
//   i_TX_Last   : byte closes the frame, captured on handshake
//   i_TX_Valid  : upstream offers a byte
//   o_TX_Ready  : a byte can be accepted this cycle
//   o_Busy      : a frame is in progress (CS_n low or in the CS gap)
//   o_SPCK      : SPI clock
//   o_MOSI      : SPI data out
//   o_CS_n      : chip select, active-low
// -----------------------------------------------------------------------------
module spi_master_tx
   import spi_master_tx_pkg::*;
#(
   parameter int SPI_MODE          = 0,
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int CS_INACTIVE_CLKS  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_Last,
   input  logic       i_TX_Valid,
   output logic       o_TX_Ready,
   output logic       o_Busy,
   output logic       o_SPCK,
   output logic       o_MOSI,
   output logic       o_CS_n
);

   localparam logic CPOL    = modeCpol(SPI_MODE);
   localparam logic CPHA    = modeCpha(SPI_MODE);
   localparam int   DLY_MAX = maxInt(CLKS_PER_HALF_BIT, CS_INACTIVE_CLKS);
   localparam int   DW      = $clog2(DLY_MAX + 1);

   // SETUP lasts H cycles. HOLD lasts H-1 cycles because the edge-16 cycle
   // itself (still in SHIFT) already counts towards the CS hold time.
   localparam logic [DW-1:0] SETUP_LAST = DW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [DW-1:0] HOLD_LAST  = DW'(CLKS_PER_HALF_BIT - 2);
   localparam logic [DW-1:0] GAP_LAST   = DW'(CS_INACTIVE_CLKS - 1);

   txState_t      r_state;
   txState_t      w_nextState;
   logic [DW-1:0] r_dlyCnt;
   logic [7:0]    r_shift;
   logic          r_mosi;
   logic          r_last;
   logic          r_csN;
   logic          r_armed;

   logic          w_ready;
   logic          w_handshake;
   logic          w_run;
   logic          w_csNNext;
   logic          w_leading;
   logic          w_trailing;
   logic          w_lastEdge;
   logic          w_byteDone;

   spi_master_tx_clkgen #(
      .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
      .CPOL              (CPOL)
   ) u_clkGen (
      .clk        (clk),
      .rst        (rst),
      .i_Run      (w_run),
      .o_SPCK     (o_SPCK),
      .o_Leading  (w_leading),
      .o_Trailing (w_trailing),
      .o_LastEdge (w_lastEdge),
      .o_ByteDone (w_byteDone)
   );

   // Next-state, ready and clock-run decode. A handshake in WAIT starts the
   // clock generator in the handshake cycle itself, so edge 1 lands exactly
   // H cycles after the handshake, the same as a no-gap continuation.
   always_comb begin
      w_nextState = r_state;
      w_ready     = 1'b0;
      w_run       = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         ST_IDLE:  w_ready = r_armed;
         ST_SETUP: if (r_dlyCnt == SETUP_LAST) w_nextState = ST_SHIFT;
         ST_SHIFT: begin
            w_run = 1'b1;
            if (w_byteDone) begin
               if (r_last) begin
                  w_nextState = ST_HOLD;
               end else begin
                  w_ready     = 1'b1;
                  w_nextState = ST_WAIT;
               end
            end
         end
         ST_WAIT:  w_ready = 1'b1;
         ST_HOLD:  if (r_dlyCnt == HOLD_LAST) w_nextState = ST_GAP;
         ST_GAP:   if (r_dlyCnt == GAP_LAST)  w_nextState = ST_IDLE;
         default:  w_nextState = ST_IDLE;
      endcase
      w_handshake = w_ready && i_TX_Valid;
      if (w_handshake) begin
         w_nextState = (r_state == ST_IDLE) ? ST_SETUP : ST_SHIFT;
         if (r_state == ST_WAIT) w_run = 1'b1;
      end
   end

   assign w_csNNext  = (w_nextState == ST_IDLE) || (w_nextState == ST_GAP);
   assign o_TX_Ready = w_ready;
   assign o_Busy     = (r_state != ST_IDLE);
   assign o_CS_n     = r_csN;
   assign o_MOSI     = r_mosi;

   // State register plus the per-state delay counter, which restarts on every
   // state change. CS_n is registered from the next state so it switches in
   // step with the state and cannot glitch. r_armed keeps ready low for the
   // first cycle after reset is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_dlyCnt <= '0;
         r_csN    <= 1'b1;
         r_armed  <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_dlyCnt <= (w_nextState != r_state) ? '0 : r_dlyCnt + 1'b1;
         r_csN    <= w_csNNext;
         r_armed  <= 1'b1;
      end
   end

   // Shift register and MOSI. With CPHA=0 bit 7 goes out as soon as the byte
   // is taken and the remaining bits advance on trailing edges 2..14; edge 16
   // leaves MOSI alone so it holds until the next byte. With CPHA=1 each of
   // the eight leading edges presents the next bit, starting with bit 7.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_mosi  <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_handshake) begin
         r_last <= i_TX_Last;
         if (CPHA) begin
            r_shift <= i_TX_Byte;
         end else begin
            r_mosi  <= i_TX_Byte[7];
            r_shift <= {i_TX_Byte[6:0], 1'b0};
         end
      end else if (CPHA ? w_leading : (w_trailing && !w_lastEdge)) begin
         r_mosi  <= r_shift[7];
         r_shift <= {r_shift[6:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_spi_master_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_tx
// Directed bench for spi_master_tx. Five instances share clk/rst:
//   0..3 : SPI modes 0..3 with H=2, G=2
//   4    : mode 0 with H=3, G=4
// A behavioural receive slave per instance samples MOSI on the edge opposite
// to the one the master launches on and records bytes, edges, CS_n low time
// and the CS_n high gap before each frame.
// -----------------------------------------------------------------------------
module tb_spi_master_tx;

   localparam int NDUT = 5;

   logic            clk;
   logic            rst;
   logic [7:0]      txByte [NDUT];
   logic [NDUT-1:0] txLast;
   logic [NDUT-1:0] txValid;
   logic [NDUT-1:0] ready;
   logic [NDUT-1:0] busy;
   logic [NDUT-1:0] spck;
   logic [NDUT-1:0] mosi;
   logic [NDUT-1:0] csN;

   int checkCount = 0;
   int errCount   = 0;

   // Slave model state
   int              csLow    [NDUT];
   int              edges    [NDUT];
   int              falls    [NDUT];
   int              highRun  [NDUT];
   int              lastGap  [NDUT];
   int              rxCount  [NDUT];
   int              bitCnt   [NDUT];
   int              idleBad  [NDUT];
   logic [7:0]      shiftIn  [NDUT];
   logic [7:0]      rxBytes  [NDUT][8];
   logic [NDUT-1:0] prevSpck;
   logic [NDUT-1:0] prevCs;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : gDut
      spi_master_tx #(
         .SPI_MODE          ((g == 4) ? 0 : g),
         .CLKS_PER_HALF_BIT ((g == 4) ? 3 : 2),
         .CS_INACTIVE_CLKS  ((g == 4) ? 4 : 2)
      ) uDut (
         .clk        (clk),
         .rst        (rst),
         .i_TX_Byte  (txByte[g]),
         .i_TX_Last  (txLast[g]),
         .i_TX_Valid (txValid[g]),
         .o_TX_Ready (ready[g]),
         .o_Busy     (busy[g]),
         .o_SPCK     (spck[g]),
         .o_MOSI     (mosi[g]),
         .o_CS_n     (csN[g])
      );
   end

   function automatic logic cpolOf(input int i);
      return (i == 2) || (i == 3);
   endfunction

   function automatic logic cphaOf(input int i);
      return (i == 1) || (i == 3);
   endfunction

   // Receive-slave model, evaluated between active clock edges
   always @(negedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         if (rst) begin
            csLow[i]   = 0;
            edges[i]   = 0;
            falls[i]   = 0;
            highRun[i] = 0;
            lastGap[i] = 0;
            rxCount[i] = 0;
            bitCnt[i]  = 0;
            idleBad[i] = 0;
            shiftIn[i] = 8'h00;
            prevSpck[i] = spck[i];
            prevCs[i]   = 1'b1;
         end else begin
            if (prevCs[i] && !csN[i]) begin
               falls[i]++;
               lastGap[i] = highRun[i];
               csLow[i]   = 0;
               edges[i]   = 0;
               bitCnt[i]  = 0;
            end
            if (csN[i]) begin
               highRun[i]++;
               if (spck[i] !== cpolOf(i)) idleBad[i]++;
            end else begin
               highRun[i] = 0;
               csLow[i]++;
               if (spck[i] !== prevSpck[i]) begin
                  edges[i]++;
                  if ((spck[i] != cpolOf(i)) ^ cphaOf(i)) begin
                     shiftIn[i] = {shiftIn[i][6:0], mosi[i]};
                     bitCnt[i]++;
                     if (bitCnt[i] == 8) begin
                        if (rxCount[i] < 8) rxBytes[i][rxCount[i]] = shiftIn[i];
                        rxCount[i]++;
                        bitCnt[i] = 0;
                     end
                  end
               end
            end
            prevSpck[i] = spck[i];
            prevCs[i]   = csN[i];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Pulse reset, check reset values one cycle in, and ready one cycle after release
   task automatic doReset();
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         checkOutput($sformatf("rstCsN%0d", i),  csN[i],   1);
         checkOutput($sformatf("rstSpck%0d", i), spck[i],  cpolOf(i));
         checkOutput($sformatf("rstMosi%0d", i), mosi[i],  0);
         checkOutput($sformatf("rstRdy%0d", i),  ready[i], 0);
         checkOutput($sformatf("rstBusy%0d", i), busy[i],  0);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      for (int i = 0; i < NDUT; i++)
         checkOutput($sformatf("rdyAfterRst%0d", i), ready[i], 1);
   endtask

   // Offer one byte and hold valid until the handshake clock edge
   task automatic applyStimulus(input int i, input logic [7:0] b, input logic l);
      int n = 0;
      @(negedge clk);
      #1;
      txValid[i] = 1'b1;
      txByte[i]  = b;
      txLast[i]  = l;
      while (ready[i] !== 1'b1 && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput($sformatf("handshake%0d", i), ready[i], 1);
      @(posedge clk);
      #1 txValid[i] = 1'b0;
   endtask

   task automatic waitIdle(input int i);
      int n = 0;
      while (busy[i] !== 1'b0 && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput($sformatf("idleReached%0d", i), busy[i], 0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      txValid = '0;
      txLast  = '0;
      for (int i = 0; i < NDUT; i++) txByte[i] = 8'h00;

      // Test 1: mode 0 single byte
      doReset();
      applyStimulus(0, 8'hA5, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("t1CsFall",  csN[0],   0);
      checkOutput("t1Busy",    busy[0],  1);
      checkOutput("t1MosiB7",  mosi[0],  1);
      checkOutput("t1RdyLow",  ready[0], 0);
      waitIdle(0);
      checkOutput("t1CsLow",   csLow[0],      36);
      checkOutput("t1Edges",   edges[0],      16);
      checkOutput("t1RxCnt",   rxCount[0],    1);
      checkOutput("t1Rx0",     rxBytes[0][0], 8'hA5);
      checkOutput("t1IdleBad", idleBad[0],    0);

      // Test 2: three-byte burst in one frame
      doReset();
      applyStimulus(0, 8'h01, 1'b0);
      applyStimulus(0, 8'h80, 1'b0);
      applyStimulus(0, 8'hFF, 1'b1);
      waitIdle(0);
      checkOutput("t2Falls",  falls[0],      1);
      checkOutput("t2CsLow",  csLow[0],      100);
      checkOutput("t2Edges",  edges[0],      48);
      checkOutput("t2RxCnt",  rxCount[0],    3);
      checkOutput("t2Rx0",    rxBytes[0][0], 8'h01);
      checkOutput("t2Rx1",    rxBytes[0][1], 8'h80);
      checkOutput("t2Rx2",    rxBytes[0][2], 8'hFF);

      // Test 3: modes 1..3
      doReset();
      for (int i = 1; i <= 3; i++) begin
         checkOutput($sformatf("t3PreIdle%0d", i), spck[i], cpolOf(i));
         applyStimulus(i, 8'h3C, 1'b1);
         waitIdle(i);
         checkOutput($sformatf("t3PostIdle%0d", i), spck[i],       cpolOf(i));
         checkOutput($sformatf("t3Edges%0d", i),    edges[i],      16);
         checkOutput($sformatf("t3CsLow%0d", i),    csLow[i],      36);
         checkOutput($sformatf("t3RxCnt%0d", i),    rxCount[i],    1);
         checkOutput($sformatf("t3Rx%0d", i),       rxBytes[i][0], 8'h3C);
         checkOutput($sformatf("t3IdleBad%0d", i),  idleBad[i],    0);
      end

      // Test 4: starvation between two bytes of one frame
      doReset();
      applyStimulus(0, 8'h11, 1'b0);
      begin
         int n = 0;
         while (ready[0] !== 1'b1 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
         end
      end
      checkOutput("t4RdyEdge16", ready[0], 1);
      repeat (10) @(negedge clk);
      #1;
      checkOutput("t4WaitCs",   csN[0],   0);
      checkOutput("t4WaitSpck", spck[0],  0);
      checkOutput("t4WaitRdy",  ready[0], 1);
      checkOutput("t4WaitBusy", busy[0],  1);
      checkOutput("t4WaitMosi", mosi[0],  1);
      checkOutput("t4WaitEdge", edges[0], 16);
      applyStimulus(0, 8'h22, 1'b1);
      waitIdle(0);
      checkOutput("t4Falls", falls[0],      1);
      checkOutput("t4Edges", edges[0],      32);
      checkOutput("t4RxCnt", rxCount[0],    2);
      checkOutput("t4Rx0",   rxBytes[0][0], 8'h11);
      checkOutput("t4Rx1",   rxBytes[0][1], 8'h22);

      // Test 5: reset mid-frame, then a clean frame
      doReset();
      applyStimulus(0, 8'hC3, 1'b1);
      begin
         int n = 0;
         while (edges[0] < 7 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
         end
      end
      checkOutput("t5Edge7", edges[0], 7);
      doReset();
      applyStimulus(0, 8'h5A, 1'b1);
      waitIdle(0);
      checkOutput("t5RxCnt", rxCount[0],    1);
      checkOutput("t5Rx0",   rxBytes[0][0], 8'h5A);
      checkOutput("t5Edges", edges[0],      16);

      // Test 6: back-to-back frames, H=3, G=4, valid held through the gap
      doReset();
      applyStimulus(4, 8'hE7, 1'b1);
      applyStimulus(4, 8'h18, 1'b1);
      waitIdle(4);
      checkOutput("t6Falls",   falls[4],      2);
      checkOutput("t6Gap",     lastGap[4],    5);
      checkOutput("t6CsLow",   csLow[4],      54);
      checkOutput("t6Edges",   edges[4],      16);
      checkOutput("t6RxCnt",   rxCount[4],    2);
      checkOutput("t6Rx0",     rxBytes[4][0], 8'hE7);
      checkOutput("t6Rx1",     rxBytes[4][1], 8'h18);
      checkOutput("t6IdleBad", idleBad[4],    0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule
